// File: rtl/inexrecur_pkg.sv
// Shared constants and entry layout for the inexact-recursion engine.
// Imported by the entry buffer and the recursion controller.
package inexrecur_pkg;

  localparam int MODE_FIFO  = 0;
  localparam int MODE_LIFO  = 1;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic [7:0] depth;
    logic [7:0] node;
    logic [7:0] edits;
    logic [7:0] cost;
  } entry_t;

endpackage

// File: rtl/inexrecur_mem_bank.sv
// Register array: one write port, NUM_P registered read ports,
// read-before-write. Ports: clk/rst_n, we/w_addr/w_data, rd_en/rd_addr/rd_zero -> rd_data.
module inexrecur_mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_P  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       w_addr,
  input  logic [DATA_W-1:0]       w_data,
  input  logic [NUM_P-1:0]        rd_en,
  input  logic [NUM_P*ADDR_W-1:0] rd_addr,
  input  logic [NUM_P-1:0]        rd_zero,
  output logic [NUM_P*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  // Read registers reset so outputs are zero immediately on reset;
  // rd_zero forces a zero result for unoccupied addresses.
  for (genvar p = 0; p < NUM_P; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data[p*DATA_W +: DATA_W] <= '0;
      end else if (rd_en[p]) begin
        rd_data[p*DATA_W +: DATA_W] <=
          rd_zero[p] ? '0 : mem[a];
      end
    end
  end

endmodule

// File: rtl/inexrecur_entry_buffer.sv
// Entry buffer: FIFO/LIFO sequential port plus NUM_RD random-read channels.
// Ports: we/w_data push, seq_re pop, ran_* random reads, count/full/empty/overflow/underflow.
module inexrecur_entry_buffer
  import inexrecur_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int LIFO   = MODE_FIFO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [DATA_W-1:0]        w_data,
  input  logic                     seq_re,
  output logic [DATA_W-1:0]        seq_r_data,
  output logic                     seq_r_valid,
  output logic [ADDR_W-1:0]        out_r_addr,
  input  logic [NUM_RD-1:0]        ran_re,
  input  logic [NUM_RD*ADDR_W-1:0] ran_r_addr,
  output logic [NUM_RD*DATA_W-1:0] ran_r_data,
  output logic [NUM_RD-1:0]        ran_r_valid,
  output logic [ADDR_W:0]          count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int NUM_P = 1 + NUM_RD;
  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   C_ONE = 1;
  localparam logic [ADDR_W:0]   C_MAX = (ADDR_W+1)'(DEPTH);
  localparam bit IS_LIFO = (LIFO == MODE_LIFO);

  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W-1:0] top_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              push_ok;
  logic              pop_ok;
  logic [NUM_RD-1:0] occ;

  logic [NUM_P-1:0]        rd_en;
  logic [NUM_P*ADDR_W-1:0] rd_addr;
  logic [NUM_P-1:0]        rd_zero;
  logic [NUM_P*DATA_W-1:0] rd_data;

  // A full buffer still takes a push when a pop frees a slot this cycle.
  assign pop_ok  = seq_re && !empty && !clr;
  assign push_ok = we && !clr && (!full || pop_ok);

  // count-1 truncated: a full LIFO wraps to DEPTH-1 correctly.
  assign top_addr = count[ADDR_W-1:0] - A_ONE;

  always_comb begin
    w_addr = wp;
    r_addr = rp;
    if (IS_LIFO) begin
      w_addr = pop_ok ? top_addr : count[ADDR_W-1:0];
      r_addr = top_addr;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) count_nxt = count + C_ONE;
    if (!push_ok && pop_ok) count_nxt = count - C_ONE;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_occ
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] off;
    assign a   = ran_r_addr[k*ADDR_W +: ADDR_W];
    assign off = a - rp;
    assign occ[k] = IS_LIFO ? ({1'b0, a} < count)
                            : ({1'b0, off} < count);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ran_r_valid[k] <= 1'b0;
      end else if (ran_re[k]) begin
        ran_r_valid[k] <= occ[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      seq_r_valid <= 1'b0;
      out_r_addr  <= '0;
    end else if (clr) begin
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      seq_r_valid <= 1'b0;
    end else begin
      if (push_ok && !IS_LIFO) wp <= wp + A_ONE;
      if (pop_ok && !IS_LIFO)  rp <= rp + A_ONE;
      count       <= count_nxt;
      full        <= (count_nxt == C_MAX);
      empty       <= (count_nxt == '0);
      seq_r_valid <= pop_ok;
      if (pop_ok) out_r_addr <= r_addr;
      if (we && !push_ok)    overflow  <= 1'b1;
      if (seq_re && !pop_ok) underflow <= 1'b1;
    end
  end

  assign rd_en   = {ran_re, pop_ok};
  assign rd_addr = {ran_r_addr, r_addr};
  assign rd_zero = {~occ, 1'b0};

  inexrecur_mem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .NUM_P  (NUM_P)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (push_ok),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_zero (rd_zero),
    .rd_data (rd_data)
  );

  assign seq_r_data = rd_data[DATA_W-1:0];
  assign ran_r_data = rd_data[NUM_P*DATA_W-1:DATA_W];

endmodule

// File: doc/inexrecur_entry_buffer.md
# inexrecur_entry_buffer

Parametrised entry buffer for the inexact-recursion engine. It stores packed search-state entries (default 32 bits) in arrival order. Entries are returned one at a time on a sequential port, either oldest-first (FIFO) or newest-first (LIFO), and `NUM_RD` independent random-read channels are available alongside. Compared with the fixed-size register file it replaces, it adds configurable depth, width and channel count, occupancy and status flags, wrap-around, and synchronous clear.

## Interface
- `DATA_W`, 32, entry width in bits
- `DEPTH`, 16, number of entries (power of two, ≥ 2)
- `ADDR_W`, `$clog2(DEPTH)`, address width
- `NUM_RD`, 2, number of random-read channels
- `LIFO`, 0, sequential-port order: 0 = FIFO, 1 = LIFO
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `clr`  in  1  synchronous clear of pointers, count and error flags
- `we`  in  1  push request
- `w_data`  in  `DATA_W`  push data
- `seq_re`  in  1  pop request
- `seq_r_data`  out  `DATA_W`  popped entry
- `seq_r_valid`  out  1  `seq_r_data` and `out_r_addr` are valid this cycle
- `out_r_addr`  out  `ADDR_W`  physical address of the popped entry
- `ran_re`  in  `NUM_RD`  per-channel random-read enable
- `ran_r_addr`  in  `NUM_RD*ADDR_W`  per-channel physical address; channel k occupies bits `[k*ADDR_W +: ADDR_W]`
- `ran_r_data`  out  `NUM_RD*DATA_W`  per-channel read data
- `ran_r_valid`  out  `NUM_RD`  per-channel: the address was occupied
- `count`  out  `ADDR_W+1`  current occupancy
- `full`, `empty`  out  1  `count == DEPTH` / `count == 0`
- `overflow`, `underflow`  out  1  sticky error flags

## Operation
- **Write pointer** `wp` and **read pointer** `rp` both wrap modulo `DEPTH`.
- **FIFO push:** writes `mem[wp]`, then `wp++`.
- **FIFO pop:** reads `mem[rp]`, then `rp++`.
- **LIFO push:** writes `mem[count]`.
- **LIFO pop:** reads `mem[count-1]`. `rp` is unused in LIFO mode.
- **Push acceptance:** a push is accepted when `!full`, or when `full` and a pop is accepted in the same cycle. A rejected push sets `overflow`.
- **Pop acceptance:** a pop is accepted when `!empty`. A rejected pop sets `underflow` and produces `seq_r_valid = 0`. There is no write-to-read bypass when empty.
- **Simultaneous FIFO push and pop:** both proceed and `count` is unchanged.
- **Simultaneous LIFO push and pop (non-empty):** the pop returns the old top, `w_data` replaces it at the same address (read-before-write), and `count` is unchanged.
- **Random read, channel k:** `ran_r_valid[k]` is 1 iff the address is occupied.
  - FIFO: occupied means `(addr - rp) mod DEPTH < count`.
  - LIFO: occupied means `addr < count`.
  - An unoccupied address returns data 0.
  - A channel with `ran_re[k] = 0` holds its previous outputs.
- **Same-address conflict:** a random read of an address written in the same cycle returns the old contents.
- **`clr`:** has priority over `we` and `seq_re`. It zeroes `wp`, `rp`, `count`, `overflow`, `underflow` and `seq_r_valid`. Memory contents are not cleared.
- **Arithmetic:** pointer arithmetic is unsigned and truncated to `ADDR_W`. `count` saturates by construction, never exceeding `DEPTH`.

## Timing
- **Sequential port:** 1-cycle latency. A pop accepted at edge n gives `seq_r_data`, `out_r_addr` and `seq_r_valid = 1` after edge n+1. `seq_r_valid` is a single-cycle pulse per pop. Data is held until the next pop.
- **Random port:** 1-cycle latency per channel, all outputs registered.
- **Flags:** `count`, `full` and `empty` are registered and update one cycle after the accepted operation.
- **Reset (asynchronous, immediate):** every output goes to 0 except `empty = 1`; pointers and `count` go to 0.
- **Reset mid-operation:** in-flight pops are discarded, and the first cycle after release returns nothing.

## Structure
- **Package `inexrecur_pkg`:** holds the `MODE_FIFO`/`MODE_LIFO` constants, the default `DATA_W`, and the entry field-layout typedef shared with the recursion controller.
- **Sub-module `inexrecur_mem_bank`:** register array with one write port and `1+NUM_RD` registered read ports, read-before-write. No reset on the array.
- **Top level:** pointer/count logic, occupancy checks and flags.

## Test plan
Bench parameters: `DEPTH = 4`, `NUM_RD = 2`.
- **FIFO order:** push `0x02010006`, `0x01000006`, `0x02000606`, then three pops → data returned in that order, `out_r_addr` 0, 1, 2, each with `seq_r_valid = 1` one cycle after its pop; `empty = 1` at the end.
- **LIFO order:** same pushes with `LIFO = 1` → pops return `0x02000606`, `0x01000006`, `0x02010006`; `out_r_addr` 2, 1, 0.
- **Full and clear:** five pushes → `full = 1` and `count = 4` after the fourth; the fifth is dropped and `overflow = 1`. Then `clr` → `count = 0`, `empty = 1`, `overflow = 0`.
- **Random read:** after the three pushes, channel 0 reads addr 2 and channel 1 reads addr 3 together → ch0 returns `0x02000606` with valid 1; ch1 returns 0 with valid 0.
- **FIFO wrap:** push 4, pop 2, push 2, then pop 4 → `out_r_addr` sequence 2, 3, 0, 1. A push and pop in the same cycle while full keeps `count = 4`.
- **Reset mid-operation:** drive `rst_n` low at `count = 3` → outputs zero and `empty = 1` without waiting for a clock edge. After release, a pop gives `seq_r_valid = 0` and `underflow = 1`.
